// File: rtl/parking_gate_arbiter_pkg.sv
// Shared types and default sizing for the parking-lot gate arbiter.
package parking_pkg;

    localparam int CAPACITY     = 8;
    localparam int OPEN_CYCLES  = 16;
    localparam int CLOSE_CYCLES = 4;
    localparam int CNT_W        = $clog2(CAPACITY + 1);

    typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;
    typedef enum logic {LANE_ENTRY, LANE_EXIT} lane_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// Lane-sensor / gate-actuator bundle; master is the lane side, slave is the arbiter.
interface parking_gate_arbiter_if
    import parking_pkg::*;
#(
    parameter int CNT_W = parking_pkg::CNT_W
);
    logic             entry_req;
    logic             exit_req;
    logic             car_passed;
    logic             gate_open;
    logic             grant_entry;
    logic             grant_exit;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             timeout;

    modport master (
        output entry_req, exit_req, car_passed,
        input  gate_open, grant_entry, grant_exit, occupancy, full, empty, timeout
    );

    modport slave (
        input  entry_req, exit_req, car_passed,
        output gate_open, grant_entry, grant_exit, occupancy, full, empty, timeout
    );
endinterface

// File: rtl/parking_gate_arbiter_timer.sv
// Loadable down-counter shared by the OPEN and CLOSE phases of the gate.
module gate_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);
    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              count <= '0;
        else if (load)         count <= value;
        else if (count != '0)  count <= count - 1'b1;
    end

    assign expired = (count == '0);
endmodule

// File: rtl/parking_gate_arbiter.sv
// Shares one barrier gate between entry and exit lanes and tracks lot occupancy.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY     = parking_pkg::CAPACITY,
    parameter int OPEN_CYCLES  = parking_pkg::OPEN_CYCLES,
    parameter int CLOSE_CYCLES = parking_pkg::CLOSE_CYCLES,
    parameter int CNT_W        = $clog2(CAPACITY + 1)
) (
    input logic                   clk,
    input logic                   rst,
    parking_gate_arbiter_if.slave bus
);
    localparam int               TMR_W   = $clog2(max2(OPEN_CYCLES, CLOSE_CYCLES));
    localparam logic [CNT_W-1:0] CAP_V   = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] OPEN_V  = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] CLOSE_V = TMR_W'(CLOSE_CYCLES - 1);

    state_t           state, state_next;
    lane_t            last_served, last_next;
    logic [CNT_W-1:0] occ_next;
    logic             timeout_next;
    logic             tmr_load, tmr_expired;
    logic [TMR_W-1:0] tmr_value;
    logic             ent_ok, ext_ok;

    assign ent_ok = bus.entry_req & ~bus.full;
    assign ext_ok = bus.exit_req  & ~bus.empty;

    gate_timer #(.W(TMR_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next   = state;
        last_next    = last_served;
        occ_next     = bus.occupancy;
        timeout_next = 1'b0;
        tmr_load     = 1'b0;
        tmr_value    = '0;
        unique case (state)
            IDLE: begin
                if (ent_ok | ext_ok) begin
                    state_next = OPEN;
                    tmr_load   = 1'b1;
                    tmr_value  = OPEN_V;
                    // On a tie the lane not served last time wins.
                    last_next  = (ent_ok && (!ext_ok || last_served == LANE_EXIT))
                                 ? LANE_ENTRY : LANE_EXIT;
                end
            end
            OPEN: begin
                if (bus.car_passed) begin
                    state_next = CLOSE;
                    tmr_load   = 1'b1;
                    tmr_value  = CLOSE_V;
                    if (last_served == LANE_ENTRY) begin
                        if (bus.occupancy != CAP_V) occ_next = bus.occupancy + 1'b1;
                    end else begin
                        if (bus.occupancy != '0)    occ_next = bus.occupancy - 1'b1;
                    end
                end else if (tmr_expired) begin
                    state_next   = CLOSE;
                    timeout_next = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_value    = CLOSE_V;
                end
            end
            CLOSE: begin
                if (tmr_expired) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            last_served     <= LANE_EXIT;
            bus.occupancy   <= '0;
            bus.full        <= 1'b0;
            bus.empty       <= 1'b1;
            bus.timeout     <= 1'b0;
            bus.gate_open   <= 1'b0;
            bus.grant_entry <= 1'b0;
            bus.grant_exit  <= 1'b0;
        end else begin
            state           <= state_next;
            last_served     <= last_next;
            bus.occupancy   <= occ_next;
            bus.full        <= (occ_next == CAP_V);
            bus.empty       <= (occ_next == '0);
            bus.timeout     <= timeout_next;
            bus.gate_open   <= (state_next == OPEN);
            bus.grant_entry <= (state_next == OPEN) && (last_next == LANE_ENTRY);
            bus.grant_exit  <= (state_next == OPEN) && (last_next == LANE_EXIT);
        end
    end
endmodule
